stream_rx_fifo: RTL and testbench
=================================

STREAM_RX_FIFO -- requirements
Module: stream_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes, power of two, 4..128.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0300_0000, word-aligned base of the 16-byte register window.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports mem_valid input 1, mem_addr input 32, mem_wdata input 32, mem_wstrb input 4: CPU native-bus request.
REQ-006 SHALL have ports mem_ready output 1, mem_rdata output 32: slave response.
REQ-007 SHALL have ports s_valid input 1, s_data input 8, s_ready output 1: byte stream from the data-processing stage.
REQ-008 SHALL have port irq output 1, level interrupt to the CPU irq vector.

Function
REQ-009 SHALL decode sel = mem_valid && mem_addr[31:4] == BASE_ADDR[31:4]; outside the window the block drives mem_ready=0 and mem_rdata=0.
REQ-010 SHALL assert mem_ready as a one-cycle registered pulse the cycle after sel && !mem_ready; mem_rdata valid only with mem_ready, 0 otherwise.
REQ-011 SHALL perform each register access once per bus transaction, at the edge where mem_ready is asserted; mem_wstrb==0 is a read, nonzero a write (byte lanes ignored, full word used).
REQ-012 SHALL map offset 0x0 DATA (read: {24'b0, head byte} and pop; write: ignored).
REQ-013 SHALL map offset 0x4 STATUS: [0] empty, [1] full, [2] stall sticky, [3] underflow sticky, [15:8] count, other bits 0; writing 1 to bit 2 or 3 clears it.
REQ-014 SHALL map offset 0x8 CTRL: [0] enable, [1] irq_en, [2] flush (write-only, reads 0), [15:8] threshold; other bits 0.
REQ-015 SHALL acknowledge offset 0xC, reading 0, ignoring writes.
REQ-016 SHALL drive s_ready = enable && !full; push when s_valid && s_ready.
REQ-017 SHALL set stall sticky in any cycle with s_valid && enable && full.
REQ-018 SHALL on DATA read when empty return 0, leave pointers unchanged, set underflow sticky.
REQ-019 SHALL on simultaneous push and pop (not empty) keep count unchanged and advance both pointers; push when full is impossible by REQ-016.
REQ-020 SHALL wrap read/write pointers modulo DEPTH; count SHALL range 0..DEPTH with full = (count==DEPTH).
REQ-021 SHALL on CTRL write with flush=1 zero pointers and count in that cycle, discarding any same-cycle push; sticky bits unaffected.
REQ-022 SHALL drive irq = irq_en && threshold!=0 && count>=threshold, registered (one cycle after count changes).

Reset
REQ-023 SHALL on resetn low asynchronously clear pointers, count, CTRL, sticky bits; mem_ready=0, mem_rdata=0, s_ready=0, irq=0.
REQ-024 SHALL, if reset asserts mid-transaction, drop the transaction without acknowledging it; after release the CPU retries normally.

Configuration
REQ-025 SHALL, with STREAM_RX_FIFO_IRQ_EN defined, implement irq_en, threshold and irq per REQ-022.
REQ-026 SHALL, without STREAM_RX_FIFO_IRQ_EN, tie irq to 0, make CTRL[1] and CTRL[15:8] read 0 and ignore writes to them; all other behaviour unchanged.

Verification
REQ-027 SHALL cover: write CTRL=0x1, stream bytes 0x11,0x22,0x33 -> STATUS count=3; three DATA reads return 0x11,0x22,0x33; then STATUS=0x0000_0001.
REQ-028 SHALL cover: enable, hold s_valid for DEPTH+2 bytes -> s_ready low after 16 pushes, full=1, stall=1; write STATUS 0x4 -> stall=0.
REQ-029 SHALL cover: DATA read on empty FIFO -> rdata=0, underflow=1, count stays 0; mem_ready exactly one cycle.
REQ-030 SHALL cover: with macro defined, CTRL=0x0403, push 3 bytes -> irq=0; 4th byte -> irq=1 next cycle; one DATA read -> irq=0.
REQ-031 SHALL cover: 10 bytes queued, CTRL write 0x5 during an active push -> count=0, empty=1, next read underflows; separately, resetn pulse mid-read -> no mem_ready, all outputs 0.

Source files
------------

// File: rtl/stream_rx_fifo.sv
// Byte-stream receive FIFO with a 16-byte CPU register window (DATA/STATUS/CTRL).
// Define STREAM_RX_FIFO_IRQ_EN to build the threshold interrupt (irq_en, threshold, irq).
module stream_rx_fifo #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          enable_q, enable_d;
    logic          stall_q, stall_d;
    logic          underflow_q, underflow_d;
    logic          mem_ready_q, mem_ready_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;

    logic          sel, access, is_wr, empty, full, push, pop, flush;
    logic          ctrl_wr, status_wr, data_rd;
    logic [1:0]    off;
    logic [31:0]   status_word, ctrl_word, rd_word;

`ifdef STREAM_RX_FIFO_IRQ_EN
    logic          irq_en_q, irq_en_d;
    logic [7:0]    threshold_q, threshold_d;
    logic          irq_q, irq_d;
`endif

    // A transaction is serviced exactly once: on the cycle before mem_ready rises.
    always_comb begin
        sel       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
        access    = sel && !mem_ready_q;
        is_wr     = |mem_wstrb;
        off       = mem_addr[3:2];
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        s_ready   = enable_q && !full;
        push      = s_valid && s_ready;
        data_rd   = access && !is_wr && (off == 2'd0);
        status_wr = access && is_wr && (off == 2'd1);
        ctrl_wr   = access && is_wr && (off == 2'd2);
        pop       = data_rd && !empty;
        flush     = ctrl_wr && mem_wdata[2];
    end

    always_comb begin
        status_word = {16'b0, 8'(count_q), 4'b0, underflow_q, stall_q, full, empty};
`ifdef STREAM_RX_FIFO_IRQ_EN
        ctrl_word   = {16'b0, threshold_q, 6'b0, irq_en_q, enable_q};
`else
        ctrl_word   = {31'b0, enable_q};
`endif
        rd_word = '0;
        case (off)
            2'd0:    rd_word = empty ? 32'b0 : {24'b0, fifo_mem[rptr_q]};
            2'd1:    rd_word = status_word;
            2'd2:    rd_word = ctrl_word;
            default: rd_word = '0;
        endcase
        mem_ready_d = access;
        mem_rdata_d = (access && !is_wr) ? rd_word : 32'b0;
    end

    // Flush overrides everything, including a push landing on the same edge.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        enable_d    = enable_q;
        stall_d     = stall_q;
        underflow_d = underflow_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
        if (ctrl_wr) enable_d = mem_wdata[0];
        if (status_wr && mem_wdata[2]) stall_d = 1'b0;
        if (status_wr && mem_wdata[3]) underflow_d = 1'b0;
        if (s_valid && enable_q && full) stall_d = 1'b1;
        if (data_rd && empty) underflow_d = 1'b1;
    end

`ifdef STREAM_RX_FIFO_IRQ_EN
    always_comb begin
        irq_en_d    = irq_en_q;
        threshold_d = threshold_q;
        if (ctrl_wr) begin
            irq_en_d    = mem_wdata[1];
            threshold_d = mem_wdata[15:8];
        end
        irq_d = irq_en_q && (threshold_q != 8'd0) && (8'(count_q) >= threshold_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_en_q    <= 1'b0;
            threshold_q <= 8'd0;
            irq_q       <= 1'b0;
        end else begin
            irq_en_q    <= irq_en_d;
            threshold_q <= threshold_d;
            irq_q       <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            enable_q    <= 1'b0;
            stall_q     <= 1'b0;
            underflow_q <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            enable_q    <= enable_d;
            stall_q     <= stall_d;
            underflow_q <= underflow_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) fifo_mem[wptr_q] <= s_data;
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;

    logic unused_bits;
    assign unused_bits = ^{mem_wdata, mem_addr[1:0]};
endmodule

// File: tb/tb_stream_rx_fifo.sv
// Randomized self-checking bench for stream_rx_fifo against a queue-based register model.
// Honours STREAM_RX_FIFO_IRQ_EN the same way as the design.
module tb_stream_rx_fifo;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0300_0000;

  logic        clk, resetn;
  logic        mem_valid, mem_ready, s_valid, s_ready, irq;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [7:0]  s_data;

  stream_rx_fifo #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and register model
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       m_en, m_irq_en, m_stall, m_und;
  logic [7:0] m_thr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_en = 0; m_irq_en = 0; m_stall = 0; m_und = 0; m_thr = 0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] v;
    v = 32'(exp_q.size()) << 8;
    v[3] = m_und;
    v[2] = m_stall;
    v[1] = (exp_q.size() == DEPTH);
    v[0] = (exp_q.size() == 0);
    return v;
  endfunction

  function automatic logic [31:0] m_ctrl();
`ifdef STREAM_RX_FIFO_IRQ_EN
    return {16'b0, m_thr, 6'b0, m_irq_en, m_en};
`else
    return {31'b0, m_en};
`endif
  endfunction

  function automatic logic m_irq();
`ifdef STREAM_RX_FIFO_IRQ_EN
    return m_irq_en && (m_thr != 0) && (exp_q.size() >= int'(m_thr));
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one bus transaction; s_valid/s_data may be held by the caller during it
  task automatic bus(input string tag, input logic [3:0] off, input logic wr, input logic [31:0] wd);
    int          n;
    logic [31:0] exp_rd, rd;
    logic        sv, sr, pre_en, pre_full, fl;
    logic [7:0]  sd;
    exp_rd = 0;
    if (!wr) begin
      case (off)
        4'h0:    exp_rd = (exp_q.size() == 0) ? 32'b0 : {24'b0, exp_q[0]};
        4'h4:    exp_rd = m_status();
        4'h8:    exp_rd = m_ctrl();
        default: exp_rd = 0;
      endcase
    end
    sv = s_valid; sr = s_ready; sd = s_data;
    pre_en = m_en; pre_full = (exp_q.size() == DEPTH);
    mem_valid = 1; mem_addr = BASE | 32'(off); mem_wdata = wd;
    mem_wstrb = wr ? 4'($urandom_range(1, 15)) : 4'h0;
    n = 0;
    do begin tick(); n++; end while (!mem_ready && n < 8);
    check_eq({tag, "_ack_latency"}, n, 1);
    rd = mem_rdata;
    mem_valid = 0; mem_wstrb = 0;
    check_eq({tag, "_rdata"}, rd, exp_rd);
    fl = wr && off == 4'h8 && wd[2];
    if (!wr && off == 4'h0) begin
      if (exp_q.size() == 0) m_und = 1;
      else void'(exp_q.pop_front());
    end
    if (wr && off == 4'h4) begin
      if (wd[2]) m_stall = 0;
      if (wd[3]) m_und = 0;
    end
    if (wr && off == 4'h8) begin
      m_en = wd[0];
`ifdef STREAM_RX_FIFO_IRQ_EN
      m_irq_en = wd[1];
      m_thr = wd[15:8];
`endif
      if (fl) exp_q.delete();
    end
    if (!fl && sv && sr) exp_q.push_back(sd);
    if (sv && pre_en && pre_full) m_stall = 1;
    s_valid = 0;
    tick();
    check_eq({tag, "_ready_pulse"}, mem_ready, 0);
    check_eq({tag, "_irq"}, irq, m_irq());
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic rdy;
    s_valid = 1; s_data = b;
    rdy = s_ready;
    check_eq("s_ready", rdy, m_en && exp_q.size() < DEPTH);
    if (m_en && exp_q.size() == DEPTH) m_stall = 1;
    tick();
    if (rdy) exp_q.push_back(b);
    s_valid = 0;
  endtask

  task automatic push_burst(input int n);
    for (int i = 0; i < n; i++) push_byte(8'($urandom));
    tick();
    check_eq("burst_irq", irq, m_irq());
  endtask

  task automatic out_of_window();
    mem_valid = 1; mem_wstrb = 0;
    mem_addr = BASE ^ (32'h10 << $urandom_range(0, 27));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("oow_ready", mem_ready, 0);
      check_eq("oow_rdata", mem_rdata, 0);
    end
    mem_valid = 0;
    tick();
  endtask

  initial begin
    logic [31:0] wd;
    resetn = 0; mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    s_valid = 0; s_data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", mem_ready, 0);
    check_eq("rst_rdata", mem_rdata, 0);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_irq", irq, 0);
    resetn = 1;
    tick();
    bus("rst_status", 4'h4, 0, 0);
    check_eq("rst_status_const", m_status(), 32'h1);

    // basic stream-in and drain
    bus("ctrl_en", 4'h8, 1, 32'h1);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    tick();
    bus("st_cnt3", 4'h4, 0, 0);
    bus("rd_11", 4'h0, 0, 0);
    bus("rd_22", 4'h0, 0, 0);
    bus("rd_33", 4'h0, 0, 0);
    bus("st_empty", 4'h4, 0, 0);

    // overfill: back-pressure, full and stall
    push_burst(DEPTH + 2);
    check_eq("full_size", exp_q.size(), DEPTH);
    bus("st_full", 4'h4, 0, 0);
    bus("clr_stall", 4'h4, 1, 32'h4);
    bus("st_nostall", 4'h4, 0, 0);
    for (int i = 0; i < DEPTH; i++) bus("drain", 4'h0, 0, 0);

    // underflow
    bus("under_rd", 4'h0, 0, 0);
    bus("under_st", 4'h4, 0, 0);
    bus("clr_under", 4'h4, 1, 32'h8);

    // threshold interrupt
    bus("irq_cfg", 4'h8, 1, 32'h0403);
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    tick();
    check_eq("irq_at3", irq, 0);
    push_byte(8'h44);
    check_eq("irq_pre", irq, 0);
    tick();
`ifdef STREAM_RX_FIFO_IRQ_EN
    check_eq("irq_at4", irq, 1);
`else
    check_eq("irq_at4", irq, 0);
`endif
    bus("irq_pop", 4'h0, 0, 0);
    check_eq("irq_after_pop", irq, 0);

    // flush during an active push
    bus("flush0", 4'h8, 1, 32'h5);
    for (int i = 0; i < 10; i++) push_byte(8'($urandom));
    tick();
    s_valid = 1; s_data = 8'hAA;
    bus("flush_push", 4'h8, 1, 32'h5);
    bus("flush_st", 4'h4, 0, 0);
    bus("flush_under", 4'h0, 0, 0);

    // random mix
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: push_burst($urandom_range(1, DEPTH / 2 + 3));
        3, 4:    bus("r_data", 4'h0, 0, 0);
        5:       bus("r_status", 4'h4, 0, 0);
        6:       bus("w_status", 4'h4, 1, $urandom);
        7: begin
          wd = $urandom & 32'hFFFF_00F8;
          wd[0] = ($urandom_range(0, 3) != 0);
          wd[1] = 1'($urandom);
          wd[2] = ($urandom_range(0, 5) == 0);
          wd[15:8] = 8'($urandom_range(0, DEPTH));
          bus("w_ctrl", 4'h8, 1, wd);
        end
        8: begin
          bus("r_ctrl", 4'h8, 0, 0);
          bus("r_resv", 4'hC, 0, 0);
          bus("w_resv", 4'hC, 1, $urandom);
          bus("w_data", 4'h0, 1, $urandom);
        end
        default: out_of_window();
      endcase
    end
    bus("r_status_end", 4'h4, 0, 0);

    // reset in the middle of a read
    bus("pre_rst_en", 4'h8, 1, 32'h1);
    push_burst(5);
    mem_valid = 1; mem_addr = BASE; mem_wstrb = 0;
    #2 resetn = 0;
    #1;
    check_eq("mid_rst_ready", mem_ready, 0);
    check_eq("mid_rst_rdata", mem_rdata, 0);
    check_eq("mid_rst_s_ready", s_ready, 0);
    check_eq("mid_rst_irq", irq, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("mid_rst_noack", mem_ready, 0);
    end
    mem_valid = 0;
    resetn = 1;
    model_reset();
    tick();
    check_eq("post_rst_noack", mem_ready, 0);
    bus("post_rst_status", 4'h4, 0, 0);
    bus("post_rst_ctrl", 4'h8, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
